// File: rtl/alu_issue_pkg.sv
// Shared ALU opcode encodings and RV64 integer-op decode constants.
// Used by the issue stage and by the ALU that consumes its output.
package alu_issue_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_SLL = 4'b0010,
        ALU_XOR = 4'b0011,
        ALU_SRL = 4'b0100,
        ALU_OR  = 4'b0101,
        ALU_AND = 4'b0110,
        ALU_ILL = 4'b1111
    } alu_opr_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // RV64 immediate shifts carry a 6-bit shamt; the bits above it must be zero.
    localparam logic [5:0] SHAMT_HI_ZERO = 6'b000000;

    typedef struct packed {
        alu_opr_e   opr;
        logic [4:0] rd;
        logic       we;
        logic       illegal;
    } issue_ctrl_t;

    localparam issue_ctrl_t CTRL_RESET = '{opr: ALU_ILL, rd: 5'd0, we: 1'b0, illegal: 1'b0};

    function automatic logic is_shift(input alu_opr_e opr);
        return (opr == ALU_SLL) || (opr == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV64 integer-op decoder: maps an instruction word plus
// register values onto an ALU opcode, operands and writeback control.
module alu_issue_decode
    import alu_issue_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output issue_ctrl_t     ctrl,
    output logic [XLEN-1:0] data1,
    output logic [XLEN-1:0] data2
);

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic        shamt_ok_s;
    logic        legal_s;
    alu_opr_e    opr_s;
    logic [4:0]  rd_s;
    logic        unused_rs1_field_s;

    assign opcode_s           = instr[6:0];
    assign funct3_s           = instr[14:12];
    assign funct7_s           = instr[31:25];
    assign rd_s               = instr[11:7];
    assign shamt_ok_s         = (instr[31:26] == SHAMT_HI_ZERO);
    assign unused_rs1_field_s = ^instr[19:15];

    // Opcode selection; anything not explicitly listed stays illegal.
    always_comb begin
        opr_s = ALU_ILL;
        case (opcode_s)
            OPC_OP: begin
                case (funct3_s)
                    F3_ADD_SUB: begin
                        if (funct7_s == F7_BASE) begin
                            opr_s = ALU_ADD;
                        end else if (funct7_s == F7_ALT) begin
                            opr_s = ALU_SUB;
                        end else begin
                            opr_s = ALU_ILL;
                        end
                    end
                    F3_SLL:     opr_s = (funct7_s == F7_BASE) ? ALU_SLL : ALU_ILL;
                    F3_XOR:     opr_s = (funct7_s == F7_BASE) ? ALU_XOR : ALU_ILL;
                    F3_SRL_SRA: opr_s = (funct7_s == F7_BASE) ? ALU_SRL : ALU_ILL;
                    F3_OR:      opr_s = (funct7_s == F7_BASE) ? ALU_OR  : ALU_ILL;
                    F3_AND:     opr_s = (funct7_s == F7_BASE) ? ALU_AND : ALU_ILL;
                    default:    opr_s = ALU_ILL;
                endcase
            end
            OPC_OP_IMM: begin
                case (funct3_s)
                    F3_ADD_SUB: opr_s = ALU_ADD;
                    F3_SLL:     opr_s = shamt_ok_s ? ALU_SLL : ALU_ILL;
                    F3_XOR:     opr_s = ALU_XOR;
                    F3_SRL_SRA: opr_s = shamt_ok_s ? ALU_SRL : ALU_ILL;
                    F3_OR:      opr_s = ALU_OR;
                    F3_AND:     opr_s = ALU_AND;
                    default:    opr_s = ALU_ILL;
                endcase
            end
            default: opr_s = ALU_ILL;
        endcase
    end

    assign legal_s = (opr_s != ALU_ILL);

    // Operand selection: register, truncated shamt, or immediate.
    always_comb begin
        data1 = {XLEN{1'b0}};
        data2 = {XLEN{1'b0}};
        if (!legal_s) begin
            data1 = {XLEN{1'b0}};
            data2 = {XLEN{1'b0}};
        end else if (opcode_s == OPC_OP) begin
            data1 = rs1_data;
            if (is_shift(opr_s)) begin
                data2 = {{(XLEN-6){1'b0}}, rs2_data[5:0]};
            end else begin
                data2 = rs2_data;
            end
        end else begin
            data1 = rs1_data;
            if (is_shift(opr_s)) begin
                data2 = {{(XLEN-6){1'b0}}, instr[25:20]};
            end else begin
                data2 = {{(XLEN-12){instr[31]}}, instr[31:20]};
            end
        end
    end

    assign ctrl.opr     = opr_s;
    assign ctrl.rd      = rd_s;
    assign ctrl.we      = legal_s && (rd_s != 5'd0);
    assign ctrl.illegal = !legal_s;

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: registered decode behind a two-entry skid buffer
// (output slot + skid slot) and a saturating illegal-instruction counter.
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_rs1_data,
    input  logic [XLEN-1:0]  in_rs2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_alu_opr,
    output logic [XLEN-1:0]  out_data1,
    output logic [XLEN-1:0]  out_data2,
    output logic [4:0]       out_rd,
    output logic             out_we,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    issue_ctrl_t       dec_ctrl_s;
    logic [XLEN-1:0]   dec_data1_s;
    logic [XLEN-1:0]   dec_data2_s;

    issue_ctrl_t       out_ctrl_r;
    logic [XLEN-1:0]   out_data1_r;
    logic [XLEN-1:0]   out_data2_r;
    logic              out_valid_r;

    issue_ctrl_t       skid_ctrl_r;
    logic [XLEN-1:0]   skid_data1_r;
    logic [XLEN-1:0]   skid_data2_r;
    logic              skid_valid_r;

    logic [CNT_W-1:0]  illegal_cnt_r;
    logic              accept_s;
    logic              out_free_s;

    alu_issue_decode #(.XLEN(XLEN)) u_decode (
        .instr    (in_instr),
        .rs1_data (in_rs1_data),
        .rs2_data (in_rs2_data),
        .ctrl     (dec_ctrl_s),
        .data1    (dec_data1_s),
        .data2    (dec_data2_s)
    );

    // Ready depends only on held state, so out_ready never reaches in_ready.
    assign in_ready   = !skid_valid_r && !rst;
    assign accept_s   = in_valid && in_ready;
    assign out_free_s = !out_valid_r || out_ready;

    // Output slot / skid slot sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            out_ctrl_r   <= CTRL_RESET;
            out_data1_r  <= {XLEN{1'b0}};
            out_data2_r  <= {XLEN{1'b0}};
            skid_valid_r <= 1'b0;
            skid_ctrl_r  <= CTRL_RESET;
            skid_data1_r <= {XLEN{1'b0}};
            skid_data2_r <= {XLEN{1'b0}};
        end else if (out_free_s) begin
            if (skid_valid_r) begin
                out_valid_r  <= 1'b1;
                out_ctrl_r   <= skid_ctrl_r;
                out_data1_r  <= skid_data1_r;
                out_data2_r  <= skid_data2_r;
                skid_valid_r <= 1'b0;
            end else if (accept_s) begin
                out_valid_r  <= 1'b1;
                out_ctrl_r   <= dec_ctrl_s;
                out_data1_r  <= dec_data1_s;
                out_data2_r  <= dec_data2_s;
            end else begin
                out_valid_r  <= 1'b0;
            end
        end else if (accept_s) begin
            // Output slot stalled: park the new instruction in the skid slot.
            skid_valid_r <= 1'b1;
            skid_ctrl_r  <= dec_ctrl_s;
            skid_data1_r <= dec_data1_s;
            skid_data2_r <= dec_data2_s;
        end else begin
            skid_valid_r <= skid_valid_r;
        end
    end

    // Saturating count of accepted illegal instructions.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s && dec_ctrl_s.illegal && (illegal_cnt_r != {CNT_W{1'b1}})) begin
            illegal_cnt_r <= illegal_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            illegal_cnt_r <= illegal_cnt_r;
        end
    end

    assign out_valid   = out_valid_r;
    assign out_alu_opr = out_ctrl_r.opr;
    assign out_data1   = out_data1_r;
    assign out_data2   = out_data2_r;
    assign out_rd      = out_ctrl_r.rd;
    assign out_we      = out_ctrl_r.we;
    assign out_illegal = out_ctrl_r.illegal;
    assign illegal_cnt = illegal_cnt_r;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed steps plus randomized valid/ready
// traffic scored against a table-driven decode model and an in-order queue.
module tb_alu_issue_stage;

    localparam int XLEN  = 64;
    localparam int CNT_W = 12;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_rs1_data;
    logic [XLEN-1:0]  in_rs2_data;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_alu_opr;
    logic [XLEN-1:0]  out_data1;
    logic [XLEN-1:0]  out_data2;
    logic [4:0]       out_rd;
    logic             out_we;
    logic             out_illegal;
    logic [CNT_W-1:0] illegal_cnt;

    alu_issue_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_rs1_data (in_rs1_data),
        .in_rs2_data (in_rs2_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_alu_opr (out_alu_opr),
        .out_data1   (out_data1),
        .out_data2   (out_data2),
        .out_rd      (out_rd),
        .out_we      (out_we),
        .out_illegal (out_illegal),
        .illegal_cnt (illegal_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [3:0]  opr;
        logic [63:0] d1;
        logic [63:0] d2;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    int   exp_cnt  = 0;
    int   nacc     = 0;
    exp_t sbq[$];

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode: funct3 lookup table, then field-level rules.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        int   tab [8];
        int   code;
        logic shift;
        tab  = '{0, 2, -1, -1, 3, 4, 5, 6};
        code = -1;
        if (ins[6:0] == 7'h33) begin
            if (ins[31:25] == 7'h00) code = tab[ins[14:12]];
            else if (ins[31:25] == 7'h20 && ins[14:12] == 3'd0) code = 1;
        end else if (ins[6:0] == 7'h13) begin
            code = tab[ins[14:12]];
            if ((code == 2 || code == 4) && ins[31:26] != 6'd0) code = -1;
        end
        e.rd = ins[11:7];
        if (code < 0) begin
            e.opr = 4'hF;
            e.d1  = 64'd0;
            e.d2  = 64'd0;
            e.we  = 1'b0;
            e.ill = 1'b1;
        end else begin
            shift = (code == 2 || code == 4);
            e.opr = code[3:0];
            e.d1  = a;
            if (ins[6:0] == 7'h33) e.d2 = shift ? (b % 64) : b;
            else e.d2 = shift ? 64'(ins[25:20]) : 64'(longint'($signed(ins[31:20])));
            e.we  = (ins[11:7] != 5'd0);
            e.ill = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int sel;
        w   = $urandom;
        sel = $urandom_range(0, 9);
        if (sel < 4) begin
            w[6:0] = 7'h33;
            case ($urandom_range(0, 3))
                0, 1:    w[31:25] = 7'h00;
                2:       w[31:25] = 7'h20;
                default: w[31:25] = w[31:25];
            endcase
        end else if (sel < 8) begin
            w[6:0] = 7'h13;
            if ($urandom_range(0, 1) == 1) w[31:26] = 6'd0;
        end
        return w;
    endfunction

    // One clock: score handshakes seen before the edge, then check holding and counter.
    task automatic tick();
        exp_t e;
        logic acc, drn, hold;
        logic [138:0] snap;
        #1;
        acc  = in_valid && in_ready;
        drn  = out_valid && out_ready;
        hold = out_valid && !out_ready && !rst;
        snap = {out_alu_opr, out_data1, out_data2, out_rd, out_we, out_illegal};
        if (rst) begin
            sbq.delete();
            exp_cnt = 0;
        end else begin
            if (drn) begin
                chk("sb_nonempty", sbq.size() > 0, 1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("out_fields", snap, e);
                end
            end
            if (acc) begin
                e = ref_decode(in_instr, in_rs1_data, in_rs2_data);
                sbq.push_back(e);
                if (e.ill && exp_cnt != CNT_MAX) exp_cnt++;
                nacc++;
            end
        end
        @(posedge clk);
        #1;
        if (hold) begin
            chk("hold_fields", {out_alu_opr, out_data1, out_data2, out_rd, out_we, out_illegal}, snap);
            chk("hold_valid", out_valid, 1);
        end
        chk("illegal_cnt", illegal_cnt, exp_cnt);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b);
        in_valid    = v;
        in_instr    = ins;
        in_rs1_data = a;
        in_rs2_data = b;
    endtask

    initial begin
        int cyc;
        int start;
        rst = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 32'd0, 64'd0, 64'd0);
        @(negedge clk);
        tick();
        tick();

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_opr", out_alu_opr, 4'hF);
        chk("rst_data1", out_data1, 0);
        chk("rst_data2", out_data2, 0);
        chk("rst_rd", out_rd, 0);
        chk("rst_we", out_we, 0);
        chk("rst_illegal", out_illegal, 0);
        chk("rst_cnt", illegal_cnt, 0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", in_ready, 1);

        // ADD x3,x1,x2
        out_ready = 1'b1;
        drive(1'b1, 32'h002081B3, 64'd5, 64'd7);
        tick();
        chk("add_valid", out_valid, 1);
        chk("add_opr", out_alu_opr, 4'h0);
        chk("add_d1", out_data1, 64'd5);
        chk("add_d2", out_data2, 64'd7);
        chk("add_rd", out_rd, 5'd3);
        chk("add_we", out_we, 1);

        // ADDI x1,x0,-1
        drive(1'b1, 32'hFFF00093, 64'd0, 64'd9);
        tick();
        chk("addi_opr", out_alu_opr, 4'h0);
        chk("addi_d2", out_data2, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_we", out_we, 1);

        // SLL x3,x1,x2 with rs2=0x41 -> shamt 1
        drive(1'b1, 32'h002091B3, 64'h1234, 64'h41);
        tick();
        chk("sll_opr", out_alu_opr, 4'h2);
        chk("sll_d2", out_data2, 64'd1);

        // SRA is unsupported
        drive(1'b1, 32'h4020D1B3, 64'h55, 64'h66);
        tick();
        chk("sra_opr", out_alu_opr, 4'hF);
        chk("sra_ill", out_illegal, 1);
        chk("sra_we", out_we, 0);
        chk("sra_d1", out_data1, 0);
        chk("sra_cnt", illegal_cnt, 1);
        drive(1'b0, 32'd0, 64'd0, 64'd0);
        tick();
        chk("drained_empty", out_valid, 0);

        // Three back-to-back offers against a stalled consumer
        out_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 64'd11, 64'd12);
        tick();
        chk("bb_ready_1", in_ready, 1);
        drive(1'b1, 32'h40208233, 64'd21, 64'd22);
        tick();
        chk("bb_ready_2", in_ready, 0);
        drive(1'b1, 32'h0020C2B3, 64'd31, 64'd32);
        tick();
        chk("bb_ready_3", in_ready, 0);
        chk("bb_valid_3", out_valid, 1);
        out_ready = 1'b1;
        tick();
        chk("bb_ready_rise", in_ready, 1);
        tick();
        drive(1'b0, 32'd0, 64'd0, 64'd0);
        tick();
        chk("bb_empty", out_valid, 0);
        chk("bb_sb_empty", sbq.size(), 0);

        // Reset with both slots full
        out_ready = 1'b0;
        drive(1'b1, 32'h4020D1B3, 64'd1, 64'd2);
        tick();
        drive(1'b1, 32'h00A00113, 64'd3, 64'd4);
        tick();
        chk("full_ready", in_ready, 0);
        rst = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("rst_mid_in_ready", in_ready, 0);
        tick();
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_in_ready2", in_ready, 0);
        chk("rst_mid_cnt", illegal_cnt, 0);
        rst = 1'b0;
        drive(1'b0, 32'd0, 64'd0, 64'd0);
        #1;
        chk("rst_mid_ready_next", in_ready, 1);
        tick();
        chk("rst_mid_no_ghost", out_valid, 0);

        // Random valid/ready stress
        start = nacc;
        cyc = 0;
        while ((nacc - start) < 10000 && cyc < 60000) begin
            drive($urandom_range(0, 9) < 7, rand_instr(), {$urandom, $urandom}, {$urandom, $urandom});
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
            cyc++;
        end
        chk("stress_accepts", (nacc - start) >= 10000, 1);
        drive(1'b0, 32'd0, 64'd0, 64'd0);
        out_ready = 1'b1;
        cyc = 0;
        while (out_valid && cyc < 10) begin
            tick();
            cyc++;
        end
        chk("stress_drained", out_valid, 0);
        chk("stress_sb_empty", sbq.size(), 0);

        // Counter saturation
        drive(1'b1, 32'h4020D1B3, 64'd7, 64'd8);
        for (int i = 0; i < CNT_MAX + 5; i++) tick();
        chk("cnt_saturated", illegal_cnt, {CNT_W{1'b1}});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
